countdown_timer: RTL
====================

// Module: countdown_timer
//
// PURPOSE
// Loadable down-counter timer: the counterpart of the free-running up-counter.
// A start pulse loads a value. The timer decrements once per PRESCALE clock
// cycles and emits a one-cycle done pulse when it reaches zero. Optional
// auto-reload turns it into a periodic tick source for blink, timeout and
// pacing logic.
//
// PARAMETERS
// WIDTH     16  width of load_value and count
// PRESCALE   1  clocks per decrement (>=1); internal prescaler is $clog2(PRESCALE+1) bits wide
//
// PORTS
// clk          in   1      system clock; all state changes on its rising edge
// reset_n      in   1      asynchronous, active-low reset
// start        in   1      single-cycle request to load and run; sampled only in IDLE
// load_value   in   WIDTH  initial/reload value; sampled with start
// auto_reload  in   1      periodic mode; sampled with start and held for the whole run
// abort        in   1      stop immediately; no done pulse
// count        out  WIDTH  current remaining count (registered)
// busy         out  1      high while in RUN
// done         out  1      one-cycle pulse when count reaches zero (registered)
//
// BEHAVIOUR
// - Reset (reset_n low, asynchronous): state=IDLE, count=0, busy=0, done=0,
//   prescaler=0, latched reload value=0, latched mode=0. Held while reset_n low.
// - States: IDLE, RUN. busy == (state==RUN), registered.
// - done defaults to 0 every cycle unless set below; never high >1 cycle per expiry.
// - IDLE, start=1, abort=0:
//   * load_value!=0: count<=load_value; latch load_value and auto_reload;
//     prescaler<=0; state<=RUN.
//   * load_value==0: done<=1 on that edge, count stays 0, remain IDLE.
// - IDLE, abort=1: no effect; start is ignored in the same cycle.
// - RUN, tick = (prescaler==PRESCALE-1). prescaler wraps to 0 on tick, else +1.
// - RUN, tick, count>1: count<=count-1.
// - RUN, tick, count==1:
//   * One-shot mode: count<=0, done<=1, state<=IDLE.
//   * Periodic mode: count<=latched value, done<=1, stay RUN.
//   * done and the new count become visible after the same edge.
// - RUN, start: ignored. load_value and auto_reload are not resampled.
// - RUN, abort=1: highest priority. Beats a coincident tick/expiry.
//   Effect: count<=0, prescaler<=0, state<=IDLE, done stays 0.
// - Timing: start sampled at edge E gives done high after edge E+L*PRESCALE
//   (L=load_value). Periodic mode repeats every L*PRESCALE cycles.
// - No wrap-around: count never decrements below 0 and never exceeds the
//   loaded value. L = 2^WIDTH-1 is legal.
// - Reset mid-run: returns to reset values at once. No done pulse.
//
// TESTING
// 1 WIDTH=8,P=1: start,L=3 at E0 -> count 3,2,1,0 after E0..E3; done=1 only after E3; busy 1->0 after E3
// 2 P=4,L=2: start at E0 -> count=1 after E4, count=0+done after E8; no done before E8
// 3 L=0 in IDLE: start -> done pulse after next edge, busy stays 0, count 0
// 4 Periodic L=2,P=1: done after E2,E4,E6; count 2,1,2,1..; busy stays 1; abort at E5 -> IDLE, count 0, no done at E6
// 5 RUN L=5: start with L=9 mid-run is ignored; abort coincident with final tick -> no done, busy 0
// 6 WIDTH=4,L=15: done after exactly 15 cycles; reset_n low mid-run asynchronously clears count/busy/done

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter: start loads a value, count decrements once per PRESCALE
// clocks and done pulses for one cycle at zero; auto_reload makes it periodic.
module countdown_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(PRESCALE + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] reload_val;
  logic             periodic;
  logic             tick;

  assign tick = (presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      presc      <= '0;
      reload_val <= '0;
      periodic   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (load_value != '0) begin
              count      <= load_value;
              reload_val <= load_value;
              periodic   <= auto_reload;
              presc      <= '0;
              state      <= RUN;
              busy       <= 1'b1;
            end else begin
              // Zero load expires immediately without entering RUN.
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            count <= '0;
            presc <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            if (count > WIDTH'(1)) begin
              count <= count - 1'b1;
            end else begin
              // count is never 0 in RUN: the loaded value is always nonzero.
              done <= 1'b1;
              if (periodic) begin
                count <= reload_val;
              end else begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
